// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that shares one external down-counter among N_REQ requesters.
// Define SCHED_ABORT_EN to add the abort/abort_ack job-cancel handshake.
module counter_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 32
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_len,
`ifdef SCHED_ABORT_EN
    input  logic               abort,
    output logic               abort_ack,
`endif
    output logic [N_REQ-1:0]   done,
    output logic [2:0]         gnt_id,
    output logic               busy,
    output logic               err,
    output logic [W-1:0]       cnt_input,
    output logic               cnt_mode,
    input  logic [W-1:0]       cnt_value,
    input  logic               cnt_status
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned IDX_W1 = IDX_W + 1;
    localparam int unsigned GNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [W-1:0]       cnt_input_q, cnt_input_d;
    logic               cnt_mode_q, cnt_mode_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               run_first_q, run_first_d;
`ifdef SCHED_ABORT_EN
    logic               abort_ack_q, abort_ack_d;
`endif

    logic               found_c;
    logic [IDX_W-1:0]   sel_c;
    logic [IDX_W-1:0]   next_ptr_c;
    logic [IDX_W1-1:0]  idx_c;
    logic [W-1:0]       len_arr [N_REQ];

    // Unpack the per-requester lengths
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            len_arr[i] = req_len[i*W +: W];
        end
    end

    // First requesting index at or after the pointer, searching upward with wrap
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        idx_c   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx_c = {1'b0, ptr_q} + IDX_W1'(off);
            if (idx_c >= IDX_W1'(N_REQ)) begin
                idx_c = idx_c - IDX_W1'(N_REQ);
            end
            if (!found_c && req[idx_c[IDX_W-1:0]]) begin
                found_c = 1'b1;
                sel_c   = idx_c[IDX_W-1:0];
            end
        end
    end

    assign next_ptr_c = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_input_d = cnt_input_q;
        cnt_mode_d  = 1'b0;
        done_d      = '0;
        busy_d      = 1'b0;
        err_d       = err_q;
        run_first_d = 1'b0;
`ifdef SCHED_ABORT_EN
        abort_ack_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_input_d = '0;
                if (found_c) begin
                    gnt_d       = sel_c;
                    cnt_input_d = len_arr[sel_c];
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                state_d     = RUN;
                run_first_d = 1'b1;
            end
            RUN: begin
                // The first RUN cycle may still show a stale status from the load
                if (!run_first_q && cnt_status && (cnt_value != '0)) begin
                    err_d = 1'b1;
                end
                if (cnt_value == '0) begin
                    cnt_input_d   = '0;
                    done_d[gnt_q] = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                ptr_d   = next_ptr_c;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SCHED_ABORT_EN
        if (abort && ((state_q == LOAD) || (state_q == RUN))) begin
            state_d     = IDLE;
            cnt_input_d = '0;
            done_d      = '0;
            ptr_d       = next_ptr_c;
            run_first_d = 1'b0;
            abort_ack_d = 1'b1;
        end
`endif

        cnt_mode_d = (state_d == RUN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_input_q <= '0;
            cnt_mode_q  <= 1'b0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            run_first_q <= 1'b0;
`ifdef SCHED_ABORT_EN
            abort_ack_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_input_q <= cnt_input_d;
            cnt_mode_q  <= cnt_mode_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            run_first_q <= run_first_d;
`ifdef SCHED_ABORT_EN
            abort_ack_q <= abort_ack_d;
`endif
        end
    end

    assign done      = done_q;
    assign gnt_id    = GNT_W'(gnt_q);
    assign busy      = busy_q;
    assign err       = err_q;
    assign cnt_input = cnt_input_q;
    assign cnt_mode  = cnt_mode_q;
`ifdef SCHED_ABORT_EN
    assign abort_ack = abort_ack_q;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed and randomized checks of counter_sched against a job-timeline model,
// with a behavioural down-counter standing in for the shared Counter.
module tb_counter_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    typedef logic [1:0] id_t;
`ifdef SCHED_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           nreset;
    logic [N-1:0]   req;
    logic [W-1:0]   len_tb [N];
    logic [N*W-1:0] req_len;
    logic [N-1:0]   done;
    logic [2:0]     gnt_id;
    logic           busy, err, cnt_mode, cnt_status;
    logic [W-1:0]   cnt_input, cnt_value;
    logic           abort_tb, force_status;
`ifdef SCHED_ABORT_EN
    logic           abort_ack;
`endif
    logic [W-1:0]   cnt_q = '0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_en  = 1'b0;
    bit          rand_en = 1'b0;
    logic [N-1:0] hold;

    always #5 clk = ~clk;

    assign req_len = {len_tb[3], len_tb[2], len_tb[1], len_tb[0]};

    // Shared Counter: loads when mode=0, counts down (with wrap) when mode=1
    always @(posedge clk) cnt_q <= cnt_mode ? cnt_q - W'(1) : cnt_input;
    assign cnt_value  = cnt_q;
    assign cnt_status = (cnt_q == '0) || force_status;

    counter_sched #(.N_REQ(N), .W(W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .req        (req),
        .req_len    (req_len),
`ifdef SCHED_ABORT_EN
        .abort      (abort_tb),
        .abort_ack  (abort_ack),
`endif
        .done       (done),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .err        (err),
        .cnt_input  (cnt_input),
        .cnt_mode   (cnt_mode),
        .cnt_value  (cnt_value),
        .cnt_status (cnt_status)
    );

    // Job-timeline model: cycle k after the sampling edge; k=1 LOAD, 2..L+2 RUN, L+3 DONE
    bit     m_act = 1'b0, m_err = 1'b0, m_ack = 1'b0, m_known = 1'b0;
    id_t    m_id = '0, m_gnt = '0, m_ptr = '0;
    longint m_len = 0, m_k = 0;
    bit     pre_idle, found;
    id_t    pick;

    always @(posedge clk) begin
        pre_idle = !m_act || (m_k == m_len + 3);
        m_ack    = 1'b0;
        if (!nreset) begin
            m_act = 1'b0;
            m_ptr = '0;
            m_gnt = '0;
            m_err = 1'b0;
        end else if (m_act) begin
            if (m_k >= 3 && m_k <= m_len + 2 && cnt_status && cnt_value != '0) m_err = 1'b1;
            if (ABORT_ON && abort_tb && m_k <= m_len + 2) begin
                m_act = 1'b0;
                m_ack = 1'b1;
                m_ptr = id_t'((int'(m_id) + 1) % N);
            end else if (m_k == m_len + 3) begin
                m_act = 1'b0;
                m_ptr = id_t'((int'(m_id) + 1) % N);
            end else begin
                m_k = m_k + 1;
            end
        end else begin
            found = 1'b0;
            pick  = '0;
            for (int off = 0; off < N; off++) begin
                if (!found && req[id_t'((int'(m_ptr) + off) % N)]) begin
                    found = 1'b1;
                    pick  = id_t'((int'(m_ptr) + off) % N);
                end
            end
            if (found) begin
                m_act = 1'b1;
                m_id  = pick;
                m_gnt = pick;
                m_len = longint'(len_tb[pick]);
                m_k   = 1;
            end
        end
        m_known = pre_idle;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    logic [N-1:0] e_done;
    always @(negedge clk) begin
        if (chk_en) begin
            e_done = (m_act && m_k == m_len + 3) ? (N'(1) << m_id) : '0;
            check("busy", 64'(busy), 64'(m_act));
            check("cnt_mode", 64'(cnt_mode), 64'(m_act && m_k >= 2 && m_k <= m_len + 2));
            check("cnt_input", 64'(cnt_input), (m_act && m_k <= m_len + 2) ? 64'(m_len) : 64'(0));
            check("done", 64'(done), 64'(e_done));
            check("gnt_id", 64'(gnt_id), 64'(m_gnt));
            check("err", 64'(err), 64'(m_err));
`ifdef SCHED_ABORT_EN
            check("abort_ack", 64'(abort_ack), 64'(m_ack));
`endif
            if (m_act && m_k >= 2 && m_k <= m_len + 2)
                check("cnt_value", 64'(cnt_value), 64'(m_len - (m_k - 2)));
            else if (!m_act && m_known)
                check("cnt_value_parked", 64'(cnt_value), 64'(0));
        end
    end

    // One cycle of requester behaviour; the only place inputs change besides directed code
    task automatic tick();
        @(negedge clk);
        if (m_act && m_k == m_len + 3 && !hold[m_id]) req[m_id] = 1'b0;
        if (m_ack) req[m_gnt] = 1'b0;
        force_status = 1'b0;
        abort_tb     = 1'b0;
        if (rand_en) begin
            for (int i = 0; i < N; i++) begin
                if (!req[id_t'(i)] && $urandom_range(0, 7) == 0) begin
                    req[id_t'(i)]    = 1'b1;
                    len_tb[id_t'(i)] = W'($urandom_range(0, 12));
                end
                if ($urandom_range(0, 15) == 0) len_tb[id_t'(i)] = W'($urandom_range(0, 12));
            end
            if (m_act && m_k <= m_len + 2 && $urandom_range(0, 15) == 0) req[m_id] = 1'b0;
            abort_tb     = ($urandom_range(0, 31) == 0);
            force_status = ($urandom_range(0, 199) == 0);
            nreset       = ($urandom_range(0, 399) != 0);
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        req    = '0;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic wait_any_done(input int max, output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (done == '0 && c < max);
        if (done == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: got no done within %0d cycles, expected a pulse", max);
        end
    endtask

    task automatic find_load(input int max, output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!(busy && !cnt_mode && done == '0) && c < max);
        if (!(busy && !cnt_mode && done == '0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL find_load: got no LOAD within %0d cycles, expected a grant", max);
        end
    endtask

    task automatic wait_run_val(input logic [W-1:0] v, input int max);
        int c = 0;
        while (!(cnt_mode && cnt_value == v) && c < max) begin
            tick();
            c++;
        end
        if (!(cnt_mode && cnt_value == v)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_value: got cnt_value %0d, expected %0d in RUN", cnt_value, v);
        end
    endtask

    task automatic drain(input int max);
        int c = 0;
        while (!(req == '0 && !busy) && c < max) begin
            tick();
            c++;
        end
        if (!(req == '0 && !busy)) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got busy=%0d req=%0h, expected idle", busy, req);
        end
    endtask

    int unsigned ord2 [4] = '{0, 1, 2, 3};
    int unsigned ord3 [4] = '{1, 2, 1, 2};

    initial begin
        int c;
        nreset = 1'b0;
        req = '0;
        hold = '0;
        abort_tb = 1'b0;
        force_status = 1'b0;
        for (int i = 0; i < N; i++) len_tb[id_t'(i)] = '0;
        do_reset();
        chk_en = 1'b1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_gnt", 64'(gnt_id), 64'(0));
        check("rst_mode", 64'(cnt_mode), 64'(0));

        // Single requester, L=5: done in the 8th cycle after sampling
        len_tb[0] = W'(5);
        req[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i >= 2 && i <= 7) check("t1_cnt_value", 64'(cnt_value), 64'(7 - i));
            if (i == 7) check("t1_no_early_done", 64'(done), 64'(0));
        end
        check("t1_done", 64'(done), 64'(4'b0001));
        check("t1_gnt", 64'(gnt_id), 64'(0));
        tick();
        check("t1_parked", 64'(cnt_value), 64'(0));

        // All four request together from reset: order 0..3, one IDLE cycle between jobs
        do_reset();
        for (int i = 0; i < N; i++) len_tb[id_t'(i)] = W'(2);
        req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            find_load(20, c);
            if (j > 0) check("t2_gap", 64'(c), 64'(2));
            check("t2_order", 64'(gnt_id), 64'(ord2[j]));
            wait_any_done(20, c);
            check("t2_latency", 64'(c + 1), 64'(5));
        end

        // Two requesters held continuously alternate
        do_reset();
        hold = 4'b0110;
        len_tb[1] = W'(1);
        len_tb[2] = W'(1);
        req = 4'b0110;
        for (int j = 0; j < 4; j++) begin
            find_load(20, c);
            check("t3_order", 64'(gnt_id), 64'(ord3[j]));
            wait_any_done(20, c);
        end
        hold = '0;
        drain(100);

        // Zero length: done 3 cycles after sampling, counter parks at 0 afterwards
        len_tb[3] = W'(0);
        req[3] = 1'b1;
        wait_any_done(10, c);
        check("t4_latency", 64'(c), 64'(3));
        check("t4_done", 64'(done), 64'(4'b1000));
        tick();
        check("t4_parked", 64'(cnt_value), 64'(0));

        // Reset in the middle of RUN drops the job
        len_tb[0] = W'(10);
        req[0] = 1'b1;
        wait_run_val(W'(7), 30);
        nreset = 1'b0;
        req = '0;
        tick();
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_done", 64'(done), 64'(0));
        check("t5_mode", 64'(cnt_mode), 64'(0));
        check("t5_input", 64'(cnt_input), 64'(0));
        check("t5_gnt", 64'(gnt_id), 64'(0));
        check("t5_err", 64'(err), 64'(0));
        nreset = 1'b1;
        tick();
        check("t5_cnt_reloaded", 64'(cnt_value), 64'(0));

        // Counter reporting terminal while non-zero sets sticky err
        len_tb[2] = W'(6);
        req[2] = 1'b1;
        wait_run_val(W'(4), 30);
        force_status = 1'b1;
        tick();
        check("t6_err_set", 64'(err), 64'(1));
        wait_any_done(20, c);
        tick();
        tick();
        check("t6_err_sticky", 64'(err), 64'(1));
        do_reset();
        check("t6_err_cleared", 64'(err), 64'(0));

        // Full-range length
        len_tb[1] = W'(255);
        req[1] = 1'b1;
        wait_any_done(400, c);
        check("t7_latency", 64'(c), 64'(258));
        check("t7_done", 64'(done), 64'(4'b0010));

`ifdef SCHED_ABORT_EN
        // Abort mid-RUN: ack pulse, no done, next requester granted
        do_reset();
        len_tb[0] = W'(8);
        len_tb[1] = W'(8);
        req = 4'b0011;
        wait_run_val(W'(3), 30);
        abort_tb = 1'b1;
        tick();
        check("t8_ack", 64'(abort_ack), 64'(1));
        check("t8_no_done", 64'(done), 64'(0));
        check("t8_idle", 64'(busy), 64'(0));
        tick();
        check("t8_next_busy", 64'(busy), 64'(1));
        check("t8_next_gnt", 64'(gnt_id), 64'(1));
        drain(50);
`endif

        // Randomized traffic checked cycle by cycle against the model
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        nreset = 1'b1;
        req = '0;
        tick();
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
